div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_pkg.sv | 12 +
 rtl/div_unit_if.sv | 28 ++
 rtl/div_step.sv | 19 +
 rtl/div_unit.sv | 115 +++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative 32-bit divider.
package div_pkg;
  localparam int DIV_W    = 32;
  localparam int DIV_ITER = 32;
  localparam int CNT_W    = $clog2(DIV_ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle of the divider, used to wire the unit to its neighbours.
interface div_unit_if;
  import div_pkg::*;

  // Request: an operation transfers on a rising edge where div_in_valid && div_in_ready.
  // Response: a result transfers on a rising edge where div_out_valid && div_out_ready;
  // s and r stay stable while div_out_valid is high and not yet taken.
  logic             div_in_valid;
  logic             div_in_ready;
  logic             div_signed;
  logic [DIV_W-1:0] x;
  logic [DIV_W-1:0] y;
  logic             div_cancel;
  logic             div_out_valid;
  logic             div_out_ready;
  logic [DIV_W-1:0] s;
  logic [DIV_W-1:0] r;

  modport master (
    output div_in_valid, div_signed, x, y, div_cancel, div_out_ready,
    input  div_in_ready, div_out_valid, s, r
  );

  modport slave (
    input  div_in_valid, div_signed, x, y, div_cancel, div_out_ready,
    output div_in_ready, div_out_valid, s, r
  );
endinterface

// File: rtl/div_step.sv
// One restoring radix-2 step: shift in the next dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] rem_in,
  input  logic             msb_in,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] rem_out,
  output logic             q_bit
);
  logic             borrow;
  logic [DIV_W:0]   trial;

  assign {borrow, trial} = {1'b0, rem_in, msb_in} - {2'b00, divisor};

  // Without a borrow the trial result is below the divisor, so its top bit is 0.
  assign q_bit   = ~borrow & ~trial[DIV_W];
  assign rem_out = q_bit ? trial[DIV_W-1:0] : {rem_in[DIV_W-2:0], msb_in};
endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned divider: 32 restoring steps on magnitudes, sign fix at the end.
module div_unit
  import div_pkg::*;
(
  input  logic             div_clk,
  input  logic             resetn,
  input  logic             div_in_valid,
  output logic             div_in_ready,
  input  logic             div_signed,
  input  logic [DIV_W-1:0] x,
  input  logic [DIV_W-1:0] y,
  input  logic             div_cancel,
  output logic             div_out_valid,
  input  logic             div_out_ready,
  output logic [DIV_W-1:0] s,
  output logic [DIV_W-1:0] r,
  output div_state_t       dbg_state
);
  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] quo;
  logic [DIV_W-1:0] rem;
  logic [DIV_W-1:0] dvs;
  logic             x_neg;
  logic             y_neg;
  logic             sgn;
  logic             y_zero;

  logic [DIV_W-1:0] step_rem;
  logic             step_q;
  logic [DIV_W-1:0] q_fin;
  logic [DIV_W-1:0] s_fin;
  logic [DIV_W-1:0] r_fin;

  assign div_in_ready = (state == IDLE);
  assign dbg_state    = state;

  // quo holds the remaining dividend bits and collects quotient bits from the bottom.
  div_step u_step (
    .rem_in  (rem),
    .msb_in  (quo[DIV_W-1]),
    .divisor (dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // A zero divisor leaves rem = |x| after 32 steps, so undoing the dividend sign restores x.
  always_comb begin
    q_fin = {quo[DIV_W-2:0], step_q};
    s_fin = q_fin;
    r_fin = step_rem;
    if (y_zero) begin
      s_fin = '1;
      r_fin = x_neg ? -step_rem : step_rem;
    end else if (sgn) begin
      s_fin = (x_neg ^ y_neg) ? -q_fin : q_fin;
      r_fin = x_neg ? -step_rem : step_rem;
    end
  end

  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      cnt           <= '0;
      quo           <= '0;
      rem           <= '0;
      dvs           <= '0;
      x_neg         <= 1'b0;
      y_neg         <= 1'b0;
      sgn           <= 1'b0;
      y_zero        <= 1'b0;
      div_out_valid <= 1'b0;
      s             <= '0;
      r             <= '0;
    end else if (div_cancel) begin
      state         <= IDLE;
      cnt           <= '0;
      div_out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (div_in_valid) begin
            quo    <= (div_signed && x[DIV_W-1]) ? -x : x;
            dvs    <= (div_signed && y[DIV_W-1]) ? -y : y;
            x_neg  <= div_signed & x[DIV_W-1];
            y_neg  <= div_signed & y[DIV_W-1];
            sgn    <= div_signed;
            y_zero <= (y == '0);
            rem    <= '0;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          rem <= step_rem;
          quo <= q_fin;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DIV_ITER - 1)) begin
            s             <= s_fin;
            r             <= r_fin;
            div_out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (div_out_ready) begin
            div_out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
